sid_stream: RTL
===============

Name: sid_stream

Overview:
- Parametrised successor to the fixed 10-cycle ID sender.
- Streams a programmable byte string (up to DEPTH characters) to the UART TX register over the rib write path, one byte per bus handshake.
- Runs as an ex-side co-unit: ex raises start_i on a decoded sID instruction, stalls on busy_o, and resumes on ready_o.
- New versus the predecessor: runtime length, bus backpressure (ack), configurable inter-byte gap, and a software-writable character table.

Parameters:
DEPTH, 16, table entries, i.e. max characters per transfer (>=10)
LEN_W, 5, width of len_i; must hold DEPTH
GAP, 0, idle cycles inserted after each acknowledged byte (0 = back-to-back)
TX_ADDR, 32'h3000_000C, UART TX data register address driven on wr_addr_o

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous reset, active-low
start_i  in  1  start request from ex; sampled only in IDLE
len_i  in  LEN_W  number of characters to send; sampled with start_i
cfg_we_i  in  1  table write enable
cfg_idx_i  in  clog2(DEPTH)  table write index
cfg_data_i  in  8  table write data
busy_o  out  1  transfer in progress
ready_o  out  1  one-cycle completion pulse
wr_req_o  out  1  bus write request
wr_addr_o  out  32  bus write address
wr_data_o  out  32  bus write data, {24'h0, byte}
wr_ack_i  in  1  bus accepted the current write

Behaviour:
- Reset (rst=0, asynchronous):
  - State IDLE; byte index and gap counter 0.
  - busy_o=0, ready_o=0, wr_req_o=0, wr_addr_o=0, wr_data_o=0.
  - Table entries 0..9 = ASCII "2023310655" (32 30 32 33 33 31 30 36 35 35); all other entries = 8'h00.
- States: IDLE, SEND, GAP, DONE.
- IDLE:
  - start_i=1 with len_i=0 -> DONE; no bus write is issued.
  - start_i=1 with len_i>0 -> SEND. Latch n = min(len_i, DEPTH); index = 0.
  - busy_o rises on the cycle after start_i is sampled.
- SEND:
  - wr_req_o=1, wr_addr_o=TX_ADDR, wr_data_o={24'h0, table[index]}.
  - Outputs are registered and remain stable until wr_ack_i=1.
  - On the ack cycle, index increments. Next state:
    - index+1==n -> DONE.
    - otherwise, GAP>0 -> GAP.
    - otherwise -> SEND; the next byte is presented on the following cycle.
  - Minimum 1 cycle per byte.
- GAP:
  - wr_req_o=0, wr_addr_o=0, wr_data_o=0.
  - Counts GAP cycles, then returns to SEND.
- DONE:
  - ready_o=1 and busy_o=1 for exactly one cycle, then IDLE with busy_o=0.
  - ready_o is 0 in every other state.
- busy_o=1 in SEND, GAP and DONE.
- Latency: total cycles from start to ready_o = 1 + sum over bytes of (wait-for-ack cycles) + (n-1)*GAP + 1.
  - With zero-wait ack and GAP=0, n=10: busy_o is high for 11 cycles.
- start_i outside IDLE is ignored; there is no queuing.
- cfg_we_i:
  - Honoured only in IDLE; ignored while busy_o=1, so the table is frozen during a transfer.
  - cfg_idx_i >= DEPTH is ignored.
  - cfg_we_i and start_i in the same IDLE cycle: the write is committed first, and the transfer sends the new value.
- wr_ack_i is ignored when wr_req_o=0.
- Index wrap is not possible because n <= DEPTH.
- Reset mid-transfer aborts immediately: no ready_o pulse and the bus request drops asynchronously.

Optional Feature:
- Macro SID_STREAM_CRLF_EN.
- Defined: after the last table byte is acked, two extra writes are issued, 8'h0D then 8'h0A, each with the same handshake and GAP spacing, before DONE.
  - len_i=0 still goes straight to DONE with no CR/LF.
- Undefined: no trailer; DONE follows the last table byte directly.

Test Plan:
- Reset defaults, start_i=1, len_i=10, wr_ack_i tied 1, GAP=0 -> bytes 32,30,32,33,33,31,30,36,35,35 appear on consecutive cycles at TX_ADDR; ready_o pulses once on cycle 11; busy_o is low afterwards.
- Backpressure: wr_ack_i low for 3 cycles on byte 2 -> wr_req_o/wr_data_o=32'h32 held stable for 4 cycles; no byte is skipped or duplicated.
- cfg writes: idx0=8'h41, idx1=8'h42; start with len_i=2, GAP=2 -> writes 41, 2 idle cycles, 42, then ready_o.
- len_i=0 -> no wr_req_o; ready_o is high 1 cycle after start. len_i=31 with DEPTH=16 -> exactly 16 writes.
- Mid-transfer: start_i re-asserted and cfg_we_i pulsed at byte 4 -> both ignored, table unchanged. rst=0 at byte 5 -> all outputs 0 immediately; no ready_o pulse.
- SID_STREAM_CRLF_EN defined, len_i=3 -> writes 32,30,32,0D,0A, then ready_o.

Source files
------------

// File: rtl/sid_stream.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sid_stream
// Purpose  : Streams a programmable ID byte string to the UART TX register
//            over the rib write path, one byte per bus handshake.
// Option   : SID_STREAM_CRLF_EN appends a CR/LF trailer to non-empty strings.
// Revision : 1.0 - initial release
// ============================================================================
module sid_stream #(
  parameter int          DEPTH   = 16,
  parameter int          LEN_W   = 5,
  parameter int          GAP     = 0,
  parameter logic [31:0] TX_ADDR = 32'h3000_000C
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_i,
  input  logic [LEN_W-1:0]         len_i,
  input  logic                     cfg_we_i,
  input  logic [$clog2(DEPTH)-1:0] cfg_idx_i,
  input  logic [7:0]               cfg_data_i,
  output logic                     busy_o,
  output logic                     ready_o,
  output logic                     wr_req_o,
  output logic [31:0]              wr_addr_o,
  output logic [31:0]              wr_data_o,
  input  logic                     wr_ack_i
);

  localparam int C_IDXW = $clog2(DEPTH);
  localparam int C_IW   = LEN_W + 1;
  localparam int C_GW   = (GAP > 1) ? $clog2(GAP) : 1;
`ifdef SID_STREAM_CRLF_EN
  localparam int C_TRL  = 2;
`else
  localparam int C_TRL  = 0;
`endif
  localparam logic [79:0] C_ID = "2023310655";

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]      r_state;
  logic [1:0]      w_next;
  logic [C_IW-1:0] r_idx;
  logic [C_IW-1:0] r_n;
  logic [C_GW-1:0] r_gap;
  logic [7:0]      r_tab [DEPTH];
  logic [C_IW-1:0] w_len_clip;
  logic [C_IW-1:0] w_total;
  logic            w_last;
  logic            w_gap_done;
  logic [7:0]      w_byte;

  // Entries past the 10-character ID shift out to zero.
  function automatic logic [7:0] f_init(input int i);
    logic [79:0] v;
    v = C_ID << (8 * i);
    return v[79:72];
  endfunction

  assign w_len_clip = (32'(len_i) > DEPTH) ? C_IW'(DEPTH) : C_IW'(len_i);
  assign w_total    = r_n + C_IW'(C_TRL);
  assign w_last     = (r_idx + C_IW'(1)) == w_total;
  assign w_gap_done = (32'(r_gap) + 32'd1) == GAP;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start_i) w_next = (len_i == '0) ? S_DONE : S_SEND;
      S_SEND: begin
        if (wr_ack_i) begin
          if (w_last)       w_next = S_DONE;
          else if (GAP > 0) w_next = S_GAP;
          else              w_next = S_SEND;
        end
      end
      S_GAP:   if (w_gap_done) w_next = S_SEND;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // The table only accepts writes in IDLE so a running transfer sees a frozen string.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idx <= '0;
      r_n   <= '0;
      r_gap <= '0;
      for (int i = 0; i < DEPTH; i++) r_tab[i] <= f_init(i);
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cfg_we_i && (32'(cfg_idx_i) < DEPTH)) r_tab[cfg_idx_i] <= cfg_data_i;
          if (start_i) begin
            r_n   <= w_len_clip;
            r_idx <= '0;
            r_gap <= '0;
          end
        end
        S_SEND: begin
          if (wr_ack_i) begin
            r_idx <= r_idx + C_IW'(1);
            r_gap <= '0;
          end
        end
        S_GAP:   r_gap <= r_gap + C_GW'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    w_byte = r_tab[r_idx[C_IDXW-1:0]];
`ifdef SID_STREAM_CRLF_EN
    if (r_idx == r_n)                    w_byte = 8'h0D;
    else if (r_idx == (r_n + C_IW'(1))) w_byte = 8'h0A;
`endif
  end

  always_comb begin
    busy_o    = (r_state != S_IDLE);
    ready_o   = (r_state == S_DONE);
    wr_req_o  = (r_state == S_SEND);
    wr_addr_o = wr_req_o ? TX_ADDR : 32'h0;
    wr_data_o = wr_req_o ? {24'h0, w_byte} : 32'h0;
  end

endmodule
`default_nettype wire
